multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Main control unit for the multicycle RV32I core. It sequences the shared ALU, memory port, register file and the immediate extender one step per cycle, and drives ImmSrc to the immediate extender. It stalls on the cache handshake so that write-through misses and fills hold the datapath in place. Supported subset: lw, sw, R-type (add/sub/and/or/slt), addi/andi/ori/slti, beq, jal.

Parameters:
- OP_W, 7, opcode width
- ST_W, 4, state register width

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- Op  in  7  Instr[6:0] from the instruction register
- Funct3  in  3  Instr[14:12]
- Funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- Stall  in  1  cache busy; the current memory access has not completed
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  cache read request
- MemWrite  out  1  cache write request
- IRWrite  out  1  instruction register load
- RegWrite  out  1  register file write
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = const 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- IllegalOp  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Moore FSM. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- The state register resets asynchronously to FETCH while RST=0. Outputs always decode from the current state, so during reset they take the FETCH values: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=000, AdrSrc=0. All other outputs are 0.
- ImmSrc is combinational from Op in every state: lw/addi-class→00, sw→01, beq→10, jal→11, otherwise 00.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR, R→EXECR, I-ALU→EXECI, beq→BEQ, jal→JAL, other→FETCH with IllegalOp=1.
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR/EXECI→ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
- Per-state outputs:
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1, MemRead=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1, ResultSrc=00.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALU op from funct decode.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALU op from funct decode.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
- Funct decode:
  - R-type: funct3 000 with Funct7b5=1 → sub.
  - I-type: funct3 000 → add regardless of Funct7b5.
  - funct3 010→slt, 110→or, 111→and.
  - Any other funct3 → add, with IllegalOp pulsed in DECODE.
- Stall handshake:
  - In FETCH, MEMREAD and MEMWRITE, Stall=1 holds the state.
  - MemRead/MemWrite and AdrSrc stay asserted for the whole stall.
  - IRWrite, PCWrite and RegWrite are forced to 0 while Stall=1.
  - Advance happens on the first edge with Stall=0; IRWrite/PCWrite fire exactly once per FETCH.
  - Stall is ignored in all other states.
- An asynchronous RST assertion mid-instruction aborts to FETCH immediately, with no partial RegWrite/MemWrite pulse after deassertion.
- Unstalled latencies: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - the opcode constants (OP_LW 0000011, OP_SW 0100011, OP_R 0110011, OP_I 0010011, OP_BEQ 1100011, OP_JAL 1101111)
  - the state encoding
  - the ALUControl, ImmSrc, ResultSrc and ALUSrc codes
- One sub-module: alu_decoder (inputs ALUOp[1:0], Funct3, Funct7b5, Op[5] → ALUControl, illegal flag).
- The FSM and the ImmSrc decode stay in the top module.

Test Plan:
- lw with Stall=0: Op=0000011 → states F,D,MA,MR,MWB; RegWrite=1 only in MWB with ResultSrc=01; ImmSrc=00 throughout.
- sw with Stall high for 3 cycles in MEMWRITE → MemWrite=1 and AdrSrc=1 for 4 cycles, then FETCH; ImmSrc=01; RegWrite never 1.
- beq with Zero=1 then Zero=0 → PCWrite=1 in BEQ only in the taken case; ALUControl=001; ImmSrc=10.
- R-type sub (Funct3=000, Funct7b5=1) → EXECR ALUControl=001; addi with Funct7b5=1 → EXECI ALUControl=000.
- FETCH with Stall=1 for 2 cycles → IRWrite/PCWrite=0 while stalled, then a single 1-cycle pulse of each.
- Op=1111111 → IllegalOp=1 for one cycle, back to FETCH, no write strobes. RST low during MEMWRITE → state=FETCH at once, MemWrite=0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes, the
// controller state encoding and the select/operation codes it drives.
package rv_ctrl_pkg;

   // Opcodes of the supported RV32I subset
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // Controller states, one datapath step each
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BEQ      = 4'd9,
      ST_JAL      = 4'd10
   } state_t;

   // ALU operation codes seen by the shared ALU
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Coarse ALU request from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Immediate extender formats
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Result mux selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_READDATA  = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALU operand A selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B selects
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // True for the states that wait on the cache handshake
   function automatic logic waitsOnCache(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: turns the FSM's coarse ALU request plus the instruction
// funct fields into the ALU operation, and flags funct3 values outside
// the supported subset.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [1:0] i_aluOp,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_op5,
   output logic [2:0] o_aluControl,
   output logic       o_functIllegal
);

   // The illegal flag looks at funct3 alone so the FSM can qualify it in
   // DECODE, before the ALU request switches over to funct decoding
   always_comb begin
      o_functIllegal = 1'b1;
      case (i_funct3)
         3'b000, 3'b010, 3'b110, 3'b111: o_functIllegal = 1'b0;
         default:                        o_functIllegal = 1'b1;
      endcase
   end

   // Pick the ALU operation; sub needs R-type (op5) and funct7b5 together so
   // that addi with bit 30 set still adds
   always_comb begin
      o_aluControl = ALU_ADD;
      case (i_aluOp)
         ALUOP_ADD: o_aluControl = ALU_ADD;
         ALUOP_SUB: o_aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               3'b000:  o_aluControl = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_aluControl = ALU_SLT;
               3'b110:  o_aluControl = ALU_OR;
               3'b111:  o_aluControl = ALU_AND;
               default: o_aluControl = ALU_ADD;
            endcase
         end
         default: o_aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle RV32I core. A Moore FSM steps the
// shared ALU, memory port and register file through each instruction and
// holds in place while the cache reports a pending access.
module multicycle_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int OP_W = 7,
   parameter int ST_W = 4
)(
   input  logic            CLK,
   input  logic            RST,
   input  logic [OP_W-1:0] Op,
   input  logic [2:0]      Funct3,
   input  logic            Funct7b5,
   input  logic            Zero,
   input  logic            Stall,
   output logic            PCWrite,
   output logic            AdrSrc,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            RegWrite,
   output logic [1:0]      ResultSrc,
   output logic [1:0]      ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [2:0]      ALUControl,
   output logic [1:0]      ImmSrc,
   output logic            IllegalOp
);

   state_t          r_state;
   logic [ST_W-1:0] w_nextState;
   logic            w_stallHold;
   logic [1:0]      w_aluOp;
   logic [2:0]      w_aluControl;
   logic            w_functIllegal;
   logic            w_isLw;
   logic            w_isSw;
   logic            w_isR;
   logic            w_isI;
   logic            w_isBeq;
   logic            w_isJal;
   logic            w_opKnown;

   assign w_isLw    = (Op == OP_LW);
   assign w_isSw    = (Op == OP_SW);
   assign w_isR     = (Op == OP_R);
   assign w_isI     = (Op == OP_I);
   assign w_isBeq   = (Op == OP_BEQ);
   assign w_isJal   = (Op == OP_JAL);
   assign w_opKnown = w_isLw | w_isSw | w_isR | w_isI | w_isBeq | w_isJal;

   // Stall only matters while the cache owns the current step
   assign w_stallHold = Stall && waitsOnCache(r_state);

   // Next-state selection; stalled cache states simply repeat themselves
   always_comb begin
      w_nextState = ST_FETCH;
      case (r_state)
         ST_FETCH:    w_nextState = w_stallHold ? ST_FETCH : ST_DECODE;
         ST_DECODE: begin
            if (w_isLw || w_isSw)  w_nextState = ST_MEMADR;
            else if (w_isR)        w_nextState = ST_EXECR;
            else if (w_isI)        w_nextState = ST_EXECI;
            else if (w_isBeq)      w_nextState = ST_BEQ;
            else if (w_isJal)      w_nextState = ST_JAL;
            else                   w_nextState = ST_FETCH;
         end
         ST_MEMADR: begin
            if (w_isLw)            w_nextState = ST_MEMREAD;
            else if (w_isSw)       w_nextState = ST_MEMWRITE;
            else                   w_nextState = ST_FETCH;
         end
         ST_MEMREAD:  w_nextState = w_stallHold ? ST_MEMREAD : ST_MEMWB;
         ST_MEMWB:    w_nextState = ST_FETCH;
         ST_MEMWRITE: w_nextState = w_stallHold ? ST_MEMWRITE : ST_FETCH;
         ST_EXECR:    w_nextState = ST_ALUWB;
         ST_EXECI:    w_nextState = ST_ALUWB;
         ST_ALUWB:    w_nextState = ST_FETCH;
         ST_BEQ:      w_nextState = ST_FETCH;
         ST_JAL:      w_nextState = ST_ALUWB;
         default:     w_nextState = ST_FETCH;
      endcase
   end

   // State register; reset aborts any instruction straight back to FETCH
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= state_t'(w_nextState);
      end
   end

   // Coarse ALU request per state, refined by the ALU decoder
   always_comb begin
      w_aluOp = ALUOP_ADD;
      case (r_state)
         ST_EXECR, ST_EXECI: w_aluOp = ALUOP_FUNCT;
         ST_BEQ:             w_aluOp = ALUOP_SUB;
         default:            w_aluOp = ALUOP_ADD;
      endcase
   end

   alu_decoder u_aluDecoder (
      .i_aluOp        (w_aluOp),
      .i_funct3       (Funct3),
      .i_funct7b5     (Funct7b5),
      .i_op5          (Op[5]),
      .o_aluControl   (w_aluControl),
      .o_functIllegal (w_functIllegal)
   );

   assign ALUControl = w_aluControl;

   // Immediate format follows the opcode in every state so the extender is
   // ready as soon as the instruction register holds a new instruction
   always_comb begin
      ImmSrc = IMM_I;
      if (w_isSw)       ImmSrc = IMM_S;
      else if (w_isBeq) ImmSrc = IMM_B;
      else if (w_isJal) ImmSrc = IMM_J;
      else              ImmSrc = IMM_I;
   end

   // Moore output decode; write strobes are masked while a cache access is
   // pending so a stalled FETCH loads IR and PC exactly once
   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      IllegalOp = 1'b0;
      case (r_state)
         ST_FETCH: begin
            MemRead   = 1'b1;
            IRWrite   = !w_stallHold;
            PCWrite   = !w_stallHold;
            ResultSrc = RES_ALURESULT;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
         end
         ST_DECODE: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_IMM;
            IllegalOp = !w_opKnown || ((w_isR || w_isI) && w_functIllegal);
         end
         ST_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         ST_MEMREAD: begin
            AdrSrc    = 1'b1;
            MemRead   = 1'b1;
            ResultSrc = RES_ALUOUT;
         end
         ST_MEMWB: begin
            ResultSrc = RES_READDATA;
            RegWrite  = 1'b1;
         end
         ST_MEMWRITE: begin
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
            ResultSrc = RES_ALUOUT;
         end
         ST_EXECR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
         end
         ST_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         ST_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
         end
         ST_BEQ: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_RS2;
            ResultSrc = RES_ALUOUT;
            PCWrite   = Zero;
         end
         ST_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALUOUT;
            PCWrite   = 1'b1;
         end
         default: begin
            PCWrite = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for the multicycle control FSM. Each driven cycle
// pushes the expected output word onto a scoreboard; a monitor pops and
// compares it on the falling edge.
module tb_multicycle_control_fsm;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   localparam int T_FETCH = 0;
   localparam int T_DECODE = 1;
   localparam int T_MEMADR = 2;
   localparam int T_MEMREAD = 3;
   localparam int T_MEMWB = 4;
   localparam int T_MEMWRITE = 5;
   localparam int T_EXECR = 6;
   localparam int T_EXECI = 7;
   localparam int T_ALUWB = 8;
   localparam int T_BEQ = 9;
   localparam int T_JAL = 10;

   logic       CLK;
   logic       RST;
   logic [6:0] Op;
   logic [2:0] Funct3;
   logic       Funct7b5;
   logic       Zero;
   logic       Stall;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] ImmSrc;
   logic       IllegalOp;

   logic [17:0] actualVec;
   string       tagQ[$];
   logic [17:0] expQ[$];
   int          assertCount;
   int          failCount;

   multicycle_control_fsm #(.OP_W(7), .ST_W(4)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Op         (Op),
      .Funct3     (Funct3),
      .Funct7b5   (Funct7b5),
      .Zero       (Zero),
      .Stall      (Stall),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .IllegalOp  (IllegalOp)
   );

   assign actualVec = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalOp};

   // Free-running clock, rising edge active
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard time limit so a stuck run still ends with a report
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected immediate format for an opcode
   function automatic logic [1:0] immOf(input logic [6:0] op);
      case (op)
         SW:      return 2'b01;
         BEQ:     return 2'b10;
         JAL:     return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Expected output word for a state, taken from the control table
   function automatic logic [17:0] expectedOutputs(input int st, input logic stall,
         input logic zero, input logic [2:0] aluc, input logic [1:0] imm,
         input logic illegal);
      logic pcw, adr, mr, mw, irw, rw, ill;
      logic [1:0] res, sa, sb;
      logic [2:0] alu;
      pcw = 0; adr = 0; mr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
      res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
      case (st)
         T_FETCH:    begin mr = 1; irw = !stall; pcw = !stall; res = 2'b10; sb = 2'b10; end
         T_DECODE:   begin sa = 2'b01; sb = 2'b01; ill = illegal; end
         T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         T_MEMREAD:  begin adr = 1; mr = 1; end
         T_MEMWB:    begin res = 2'b01; rw = 1; end
         T_MEMWRITE: begin adr = 1; mw = 1; end
         T_EXECR:    begin sa = 2'b10; sb = 2'b00; alu = aluc; end
         T_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = aluc; end
         T_ALUWB:    begin rw = 1; end
         T_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = zero; end
         T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         default:    begin pcw = 0; end
      endcase
      return {pcw, adr, mr, mw, irw, rw, res, sa, sb, alu, imm, ill};
   endfunction

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [17:0] actual,
         input logic [17:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %05h expected %05h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs and queue what the DUT should show
   task automatic applyStimulus(input string tag, input int st, input logic [6:0] op,
         input logic [2:0] f3, input logic f7, input logic zero, input logic stall,
         input logic [2:0] aluc, input logic illegal);
      Op = op; Funct3 = f3; Funct7b5 = f7; Zero = zero; Stall = stall;
      tagQ.push_back(tag);
      expQ.push_back(expectedOutputs(st, stall, zero, aluc, immOf(op), illegal));
      @(posedge CLK);
      #1;
   endtask

   // Monitor: compare queued expectations on the falling edge
   initial begin : monitor
      string       t;
      logic [17:0] e;
      forever begin
         @(negedge CLK);
         if (expQ.size() > 0) begin
            t = tagQ.pop_front();
            e = expQ.pop_front();
            checkOutput(t, actualVec, e);
         end
      end
   end

   // Main stimulus sequence
   initial begin
      assertCount = 0;
      failCount = 0;
      RST = 1'b0; Op = LW; Funct3 = 3'b010; Funct7b5 = 0; Zero = 0; Stall = 0;
      @(posedge CLK);
      #1;
      $display("[TB] reset values");
      applyStimulus("reset0", T_FETCH, LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("reset1", T_FETCH, LW, 3'b010, 0, 0, 0, 3'b000, 0);
      RST = 1'b1;

      $display("[TB] lw unstalled");
      applyStimulus("lwF",  T_FETCH,   LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lwD",  T_DECODE,  LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lwMA", T_MEMADR,  LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lwMR", T_MEMREAD, LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lwWB", T_MEMWB,   LW, 3'b010, 0, 0, 0, 3'b000, 0);

      $display("[TB] sw with MEMWRITE stall");
      applyStimulus("swF",  T_FETCH,  SW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("swD",  T_DECODE, SW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("swMA", T_MEMADR, SW, 3'b010, 0, 0, 0, 3'b000, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus("swMWstall", T_MEMWRITE, SW, 3'b010, 0, 0, 1, 3'b000, 0);
      applyStimulus("swMW", T_MEMWRITE, SW, 3'b010, 0, 0, 0, 3'b000, 0);

      $display("[TB] beq taken and not taken");
      applyStimulus("beqF",  T_FETCH,  BEQ, 3'b000, 0, 1, 0, 3'b000, 0);
      applyStimulus("beqD",  T_DECODE, BEQ, 3'b000, 0, 1, 0, 3'b000, 0);
      applyStimulus("beqT",  T_BEQ,    BEQ, 3'b000, 0, 1, 0, 3'b000, 0);
      applyStimulus("beqF2", T_FETCH,  BEQ, 3'b000, 0, 0, 0, 3'b000, 0);
      applyStimulus("beqD2", T_DECODE, BEQ, 3'b000, 0, 0, 0, 3'b000, 0);
      applyStimulus("beqNT", T_BEQ,    BEQ, 3'b000, 0, 0, 0, 3'b000, 0);

      $display("[TB] R-type and I-type funct decode");
      applyStimulus("subF",  T_FETCH,  RT, 3'b000, 1, 0, 0, 3'b000, 0);
      applyStimulus("subD",  T_DECODE, RT, 3'b000, 1, 0, 0, 3'b000, 0);
      applyStimulus("subEX", T_EXECR,  RT, 3'b000, 1, 0, 0, 3'b001, 0);
      applyStimulus("subWB", T_ALUWB,  RT, 3'b000, 1, 0, 0, 3'b000, 0);
      applyStimulus("andF",  T_FETCH,  RT, 3'b111, 0, 0, 0, 3'b000, 0);
      applyStimulus("andD",  T_DECODE, RT, 3'b111, 0, 0, 0, 3'b000, 0);
      applyStimulus("andEX", T_EXECR,  RT, 3'b111, 0, 0, 0, 3'b010, 0);
      applyStimulus("andWB", T_ALUWB,  RT, 3'b111, 0, 0, 0, 3'b000, 0);
      applyStimulus("sltF",  T_FETCH,  RT, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("sltD",  T_DECODE, RT, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("sltEX", T_EXECR,  RT, 3'b010, 0, 0, 0, 3'b101, 0);
      applyStimulus("sltWB", T_ALUWB,  RT, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("addiF", T_FETCH,  IT, 3'b000, 1, 0, 0, 3'b000, 0);
      applyStimulus("addiD", T_DECODE, IT, 3'b000, 1, 0, 0, 3'b000, 0);
      applyStimulus("addiEX",T_EXECI,  IT, 3'b000, 1, 0, 0, 3'b000, 0);
      applyStimulus("addiWB",T_ALUWB,  IT, 3'b000, 1, 0, 0, 3'b000, 0);
      applyStimulus("oriF",  T_FETCH,  IT, 3'b110, 0, 0, 0, 3'b000, 0);
      applyStimulus("oriD",  T_DECODE, IT, 3'b110, 0, 0, 0, 3'b000, 0);
      applyStimulus("oriEX", T_EXECI,  IT, 3'b110, 0, 0, 0, 3'b011, 0);
      applyStimulus("oriWB", T_ALUWB,  IT, 3'b110, 0, 0, 0, 3'b000, 0);

      $display("[TB] FETCH stall then jal");
      applyStimulus("jalFstall0", T_FETCH, JAL, 3'b000, 0, 0, 1, 3'b000, 0);
      applyStimulus("jalFstall1", T_FETCH, JAL, 3'b000, 0, 0, 1, 3'b000, 0);
      applyStimulus("jalF",  T_FETCH,  JAL, 3'b000, 0, 0, 0, 3'b000, 0);
      applyStimulus("jalD",  T_DECODE, JAL, 3'b000, 0, 0, 0, 3'b000, 0);
      applyStimulus("jalJ",  T_JAL,    JAL, 3'b000, 0, 0, 0, 3'b000, 0);
      applyStimulus("jalWB", T_ALUWB,  JAL, 3'b000, 0, 0, 0, 3'b000, 0);

      $display("[TB] illegal opcode and funct3");
      applyStimulus("badF",  T_FETCH,  BAD, 3'b000, 0, 0, 0, 3'b000, 0);
      applyStimulus("badD",  T_DECODE, BAD, 3'b000, 0, 0, 0, 3'b000, 1);
      applyStimulus("badF2", T_FETCH,  RT,  3'b001, 0, 0, 0, 3'b000, 0);
      applyStimulus("f3D",   T_DECODE, RT,  3'b001, 0, 0, 0, 3'b000, 1);
      applyStimulus("f3EX",  T_EXECR,  RT,  3'b001, 0, 0, 0, 3'b000, 0);
      applyStimulus("f3WB",  T_ALUWB,  RT,  3'b001, 0, 0, 0, 3'b000, 0);

      $display("[TB] lw with MEMREAD stall");
      applyStimulus("lw2F",  T_FETCH,  LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lw2D",  T_DECODE, LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lw2MA", T_MEMADR, LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lw2MRs0", T_MEMREAD, LW, 3'b010, 0, 0, 1, 3'b000, 0);
      applyStimulus("lw2MRs1", T_MEMREAD, LW, 3'b010, 0, 0, 1, 3'b000, 0);
      applyStimulus("lw2MR", T_MEMREAD, LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("lw2WB", T_MEMWB,   LW, 3'b010, 0, 0, 0, 3'b000, 0);

      $display("[TB] asynchronous reset during MEMWRITE");
      applyStimulus("rsF",  T_FETCH,  SW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("rsD",  T_DECODE, SW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("rsMA", T_MEMADR, SW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("rsMW", T_MEMWRITE, SW, 3'b010, 0, 0, 1, 3'b000, 0);
      Stall = 1'b0;
      #1;
      RST = 1'b0;
      #1;
      checkOutput("asyncReset", actualVec,
                  expectedOutputs(T_FETCH, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0));
      @(posedge CLK);
      #1;
      applyStimulus("rsHold", T_FETCH, SW, 3'b010, 0, 0, 0, 3'b000, 0);
      RST = 1'b1;
      applyStimulus("rsF2",  T_FETCH,  LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("rsD2",  T_DECODE, LW, 3'b010, 0, 0, 0, 3'b000, 0);
      applyStimulus("rsMA2", T_MEMADR, LW, 3'b010, 0, 0, 0, 3'b000, 0);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge CLK);
      checkOutput("scoreboardDrain", 18'(expQ.size()), 18'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
